// File: rtl/fpu_mul_arbiter_if.sv
// Bundled request/response/multiplier signals for fpu_mul_arbiter.
// The slave modport is the arbiter side; the master modport is the
// requesters plus the multiplier datapath.
interface fpu_mul_arbiter_if #(
  parameter int unsigned NUM_REQ = 4
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [32*NUM_REQ-1:0] req_a;
  logic [32*NUM_REQ-1:0] req_b;
  logic [31:0]           mul_a;
  logic [31:0]           mul_b;
  logic [31:0]           mul_result;
  logic [NUM_REQ-1:0]    rsp_valid;
  logic [NUM_REQ-1:0]    rsp_ready;
  logic [31:0]           rsp_result;
  logic                  busy;
  logic [31:0]           op_count;

  modport slave (
    input  req_valid, req_a, req_b, mul_result, rsp_ready,
    output req_ready, mul_a, mul_b, rsp_valid, rsp_result, busy, op_count
  );

  modport master (
    output req_valid, req_a, req_b, mul_result, rsp_ready,
    input  req_ready, mul_a, mul_b, rsp_valid, rsp_result, busy, op_count
  );
endinterface

// File: rtl/fpu_mul_arbiter.sv
// Round-robin arbiter sharing one fixed-latency multiplier among NUM_REQ
// requesters, one operation in flight at a time.
// Optional feature: define FPU_ARB_STATS_EN to enable the op_count
// completed-operation counter; otherwise op_count is tied to zero.
module fpu_mul_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned MUL_LAT = 1
) (
  input logic              clk,
  input logic              rst_n,
  fpu_mul_arbiter_if.slave bus
);
  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [2:0]         cnt_q, cnt_d;
  logic [31:0]        mul_a_q, mul_a_d;
  logic [31:0]        mul_b_q, mul_b_d;
  logic [31:0]        rsp_result_q, rsp_result_d;
  logic [IDX_W-1:0]   win;
  logic               found;
  int unsigned        idx;
  logic [NUM_REQ-1:0] req_ready;
  logic [NUM_REQ-1:0] rsp_valid;
  logic               req_hs;
  logic               rsp_hs;

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = (32'(last_q) + k) % NUM_REQ;
      if (!found && bus.req_valid[IDX_W'(idx)]) begin
        found = 1'b1;
        win   = IDX_W'(idx);
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req_hs) state_d = EXEC;
      EXEC:    if (cnt_q == 3'd0) state_d = RESP;
      RESP:    if (rsp_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs; req_ready is also gated by rst_n so it is low during reset.
  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    if (rst_n && (state_q == IDLE) && found) req_ready[win] = 1'b1;
    if (state_q == RESP) rsp_valid[owner_q] = 1'b1;
    req_hs = |(bus.req_valid & req_ready);
    rsp_hs = (state_q == RESP) && bus.rsp_ready[owner_q];
  end

  // Datapath next values: operand latch on grant, countdown, result capture.
  always_comb begin
    last_d       = last_q;
    owner_d      = owner_q;
    cnt_d        = cnt_q;
    mul_a_d      = mul_a_q;
    mul_b_d      = mul_b_q;
    rsp_result_d = rsp_result_q;
    if (req_hs) begin
      mul_a_d = bus.req_a[{win, 5'b0} +: 32];
      mul_b_d = bus.req_b[{win, 5'b0} +: 32];
      owner_d = win;
      last_d  = win;
      cnt_d   = 3'(MUL_LAT);
    end else if (state_q == EXEC) begin
      if (cnt_q != 3'd0) cnt_d = cnt_q - 3'd1;
      else               rsp_result_d = bus.mul_result;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q       <= IDX_W'(NUM_REQ - 1);
      owner_q      <= '0;
      cnt_q        <= '0;
      mul_a_q      <= '0;
      mul_b_q      <= '0;
      rsp_result_q <= '0;
    end else begin
      last_q       <= last_d;
      owner_q      <= owner_d;
      cnt_q        <= cnt_d;
      mul_a_q      <= mul_a_d;
      mul_b_q      <= mul_b_d;
      rsp_result_q <= rsp_result_d;
    end
  end

`ifdef FPU_ARB_STATS_EN
  logic [31:0] op_count_q;

  // Completed-operation counter, wraps naturally at 32 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      op_count_q <= '0;
    else if (rsp_hs) op_count_q <= op_count_q + 32'd1;
  end

  assign bus.op_count = op_count_q;
`else
  assign bus.op_count = '0;
`endif

  assign bus.req_ready  = req_ready;
  assign bus.rsp_valid  = rsp_valid;
  assign bus.mul_a      = mul_a_q;
  assign bus.mul_b      = mul_b_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.busy       = (state_q != IDLE);
endmodule

// File: tb/tb_fpu_mul_arbiter.sv
// Directed bench for fpu_mul_arbiter: one MUL_LAT=1/NUM_REQ=4 instance and
// one MUL_LAT=3/NUM_REQ=2 instance, each fed by a table-driven multiplier.
module tb_fpu_mul_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int unsigned pass_cnt = 0;
  int unsigned total_cnt = 0;

`ifdef FPU_ARB_STATS_EN
  localparam int unsigned STATS = 1;
`else
  localparam int unsigned STATS = 0;
`endif

  always #5 clk = ~clk;

  fpu_mul_arbiter_if #(.NUM_REQ(4)) bus0 ();
  fpu_mul_arbiter_if #(.NUM_REQ(2)) bus3 ();

  fpu_mul_arbiter #(.NUM_REQ(4), .MUL_LAT(1)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  fpu_mul_arbiter #(.NUM_REQ(2), .MUL_LAT(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

  // Known float products; anything else yields a+b so results stay distinct.
  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h40000000 && b == 32'h40400000) return 32'h40C00000;
    if (a == 32'h3FC00000 && b == 32'h3FC00000) return 32'h40100000;
    if (a == 32'hC0000000 && b == 32'h40800000) return 32'hC1000000;
    return a + b;
  endfunction

  logic [31:0] p0 = '0;
  logic [31:0] q1 = '0, q2 = '0, q3 = '0;

  // Multiplier models: latency 1 and latency 3 register pipelines.
  always @(posedge clk) begin
    p0 <= fmul(bus0.mul_a, bus0.mul_b);
    q1 <= fmul(bus3.mul_a, bus3.mul_b);
    q2 <= q1;
    q3 <= q2;
  end
  assign bus0.mul_result = p0;
  assign bus3.mul_result = q3;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      $error("check %s mismatched", tag);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] exp_res [4];

  initial begin
    exp_res[0] = 32'h00000003;
    exp_res[1] = 32'h00000123;
    exp_res[2] = 32'h40100000;
    exp_res[3] = 32'h00001234;

    bus0.req_valid = 4'b0001;
    bus0.req_a = '0;
    bus0.req_b = '0;
    bus0.rsp_ready = '1;
    bus0.req_a[31:0] = 32'h40000000;
    bus0.req_b[31:0] = 32'h40400000;
    bus3.req_valid = '0;
    bus3.req_a = '0;
    bus3.req_b = '0;
    bus3.rsp_ready = '1;

    // Reset values, with a request already pending.
    step();
    step();
    chk("rst_req_ready", 32'(bus0.req_ready), 32'h0);
    chk("rst_mul_a", bus0.mul_a, 32'h0);
    chk("rst_mul_b", bus0.mul_b, 32'h0);
    chk("rst_rsp_result", bus0.rsp_result, 32'h0);
    chk("rst_rsp_valid", 32'(bus0.rsp_valid), 32'h0);
    chk("rst_busy", 32'(bus0.busy), 32'h0);
    chk("rst_op_count", bus0.op_count, 32'h0);

    // Single request 2.0*3.0.
    rst_n = 1'b1;
    #1;
    chk("single_req_ready", 32'(bus0.req_ready), 32'h1);
    step();
    bus0.req_valid = '0;
    chk("single_busy", 32'(bus0.busy), 32'h1);
    chk("single_mul_a", bus0.mul_a, 32'h40000000);
    chk("single_mul_b", bus0.mul_b, 32'h40400000);
    step();
    chk("single_rsp_early", 32'(bus0.rsp_valid), 32'h0);
    step();
    chk("single_rsp_valid", 32'(bus0.rsp_valid), 32'h1);
    chk("single_rsp_result", bus0.rsp_result, 32'h40C00000);
    step();
    chk("single_idle_busy", 32'(bus0.busy), 32'h0);
    chk("single_idle_rsp", 32'(bus0.rsp_valid), 32'h0);
    chk("single_op_count", bus0.op_count, (STATS != 0) ? 32'd1 : 32'd0);

    // Simultaneous requests from reset: grant order 0,1,2,3,0.
    rst_n = 1'b0;
    bus0.req_a = {32'h00001000, 32'h3FC00000, 32'h00000100, 32'h00000001};
    bus0.req_b = {32'h00000234, 32'h3FC00000, 32'h00000023, 32'h00000002};
    bus0.req_valid = 4'b1111;
    step();
    rst_n = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("rr_req_ready_%0d", i), 32'(bus0.req_ready), 32'(4'b0001 << (i % 4)));
      step();
      step();
      chk($sformatf("rr_rsp_early_%0d", i), 32'(bus0.rsp_valid), 32'h0);
      step();
      chk($sformatf("rr_rsp_valid_%0d", i), 32'(bus0.rsp_valid), 32'(4'b0001 << (i % 4)));
      chk($sformatf("rr_rsp_result_%0d", i), bus0.rsp_result, exp_res[i % 4]);
      step();
    end
    chk("rr_op_count", bus0.op_count, (STATS != 0) ? 32'd5 : 32'd0);

    // Response backpressure on requester 1 while requester 3 waits.
    bus0.req_valid = 4'b1010;
    bus0.req_a[63:32] = 32'hC0000000;
    bus0.req_b[63:32] = 32'h40800000;
    bus0.rsp_ready = 4'b1101;
    #1;
    chk("bp_req_ready", 32'(bus0.req_ready), 32'h2);
    step();
    step();
    step();
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("bp_rsp_valid_%0d", i), 32'(bus0.rsp_valid), 32'h2);
      chk($sformatf("bp_rsp_result_%0d", i), bus0.rsp_result, 32'hC1000000);
      chk($sformatf("bp_req_blocked_%0d", i), 32'(bus0.req_ready), 32'h0);
      step();
    end
    bus0.rsp_ready = 4'b1111;
    step();
    bus0.req_valid = 4'b1000;
    #1;
    chk("bp_next_grant", 32'(bus0.req_ready), 32'h8);
    chk("bp_op_count", bus0.op_count, (STATS != 0) ? 32'd6 : 32'd0);

    // Reset one cycle after a grant to requester 3.
    step();
    chk("mid_mul_a", bus0.mul_a, 32'h00001000);
    step();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_mul_a", bus0.mul_a, 32'h0);
    chk("mid_rst_mul_b", bus0.mul_b, 32'h0);
    chk("mid_rst_busy", 32'(bus0.busy), 32'h0);
    chk("mid_rst_rsp_result", bus0.rsp_result, 32'h0);
    chk("mid_rst_op_count", bus0.op_count, 32'h0);
    chk("mid_rst_req_ready", 32'(bus0.req_ready), 32'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("mid_rst_rsp_valid_%0d", i), 32'(bus0.rsp_valid), 32'h0);
    end
    bus0.req_valid = 4'b1001;
    rst_n = 1'b1;
    #1;
    chk("mid_after_first", 32'(bus0.req_ready), 32'h1);
    bus0.req_valid = '0;

    // MUL_LAT=3 instance: response after edge T+4 with the pipelined product.
    bus3.req_valid = 2'b01;
    bus3.req_a[31:0] = 32'h40000000;
    bus3.req_b[31:0] = 32'h40400000;
    #1;
    chk("lat3_req_ready", 32'(bus3.req_ready), 32'h1);
    step();
    bus3.req_valid = '0;
    for (int i = 1; i <= 3; i++) begin
      step();
      chk($sformatf("lat3_rsp_early_%0d", i), 32'(bus3.rsp_valid), 32'h0);
    end
    step();
    chk("lat3_rsp_valid", 32'(bus3.rsp_valid), 32'h1);
    chk("lat3_rsp_result", bus3.rsp_result, 32'h40C00000);
    step();
    chk("lat3_idle_busy", 32'(bus3.busy), 32'h0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
